// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared link-layer constants for the TX/RX PHY path
package phy_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  localparam logic [31:0] COM_WORD_DEF = 32'hBCBCBCBC;
  localparam logic [31:0] PAD_WORD_DEF = 32'h7C7C7C7C;
  localparam int          LANE_COUNT   = 2;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that stops at LIMIT, with synchronous clear
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != LIM)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/phy_tx_link_ctrl.sv
// rtl/phy_tx_link_ctrl.sv - TX link bring-up: COM training, user-word gating, lane-even drain
module phy_tx_link_ctrl
  import phy_pkg::*;
#(
  parameter int          TS_COUNT = 16,
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] COM_WORD = COM_WORD_DEF,
  parameter logic [31:0] PAD_WORD = PAD_WORD_DEF
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic                  init_req,
  input  logic [LANE_COUNT-1:0] lane_ready,
  input  logic [31:0]           data_in,
  input  logic                  valid_in,
  output logic                  in_ready,
  output logic [31:0]           data_out,
  output logic                  valid_out,
  output logic                  active,
  output logic [2:0]            state,
  output logic                  train_err
);

  localparam int WCW = $clog2(TS_COUNT + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WC_FULL = WCW'(TS_COUNT);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        err_q, err_d;
  logic        parity_q, parity_d;

  logic [WCW-1:0] word_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic           word_en, tmo_en, train_entry;
  logic           lanes_up, words_done;

  assign lanes_up   = &lane_ready;
  assign words_done = (word_cnt == WC_FULL);
  assign in_ready   = (state_q == ST_ACTIVE) && init_req;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    parity_d = parity_q;
    word_en  = 1'b0;
    tmo_en   = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        data_d = '0;
        if (init_req) begin
          state_d = ST_TRAIN;
          err_d   = 1'b0;
        end
      end
      ST_TRAIN: begin
        if (!init_req) begin
          state_d = ST_IDLE;
        end else if (!words_done) begin
          data_d  = COM_WORD;
          valid_d = 1'b1;
          word_en = 1'b1;
        end else if (lanes_up) begin
          state_d  = ST_ACTIVE;
          parity_d = 1'b0;
        end else if (tmo_cnt == TO_LAST) begin
          // this wait cycle is the TIMEOUT-th one since the last COM word
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!lanes_up) begin
          state_d = ST_TRAIN;
          if (parity_q) begin
            data_d   = PAD_WORD;
            valid_d  = 1'b1;
            parity_d = 1'b0;
          end
        end else if (!init_req) begin
          state_d = ST_DRAIN;
        end else if (valid_in) begin
          data_d   = data_in;
          valid_d  = 1'b1;
          parity_d = ~parity_q;
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        if (parity_q) begin
          data_d   = PAD_WORD;
          valid_d  = 1'b1;
          parity_d = 1'b0;
        end
      end
      default: state_d = ST_RESET;
    endcase
    active_d = (state_d == ST_ACTIVE) || (state_d == ST_DRAIN);
  end

  assign train_entry = (state_d == ST_TRAIN) && (state_q != ST_TRAIN);

  sat_counter #(.WIDTH(WCW), .LIMIT(TS_COUNT)) u_word_cnt (
    .clk   (clk_2f),
    .rst_n (reset),
    .clr   (train_entry),
    .en    (word_en),
    .count (word_cnt)
  );

  sat_counter #(.WIDTH(TCW), .LIMIT(TIMEOUT)) u_tmo_cnt (
    .clk   (clk_2f),
    .rst_n (reset),
    .clr   (train_entry),
    .en    (tmo_en),
    .count (tmo_cnt)
  );

  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      err_q    <= err_d;
      parity_q <= parity_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign state     = state_q;
  assign train_err = err_q;

endmodule

// File: tb/tb_phy_tx_link_ctrl.sv
// tb/tb_phy_tx_link_ctrl.sv - scoreboard bench for phy_tx_link_ctrl
module tb_phy_tx_link_ctrl;

  localparam logic [31:0] COM = 32'hBCBCBCBC;
  localparam logic [31:0] PAD = 32'h7C7C7C7C;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic        init_req;
  logic [1:0]  lane_ready;
  logic [31:0] data_in;
  logic        valid_in;
  logic        in_ready;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic [2:0]  state;
  logic        train_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  phy_tx_link_ctrl dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .init_req   (init_req),
    .lane_ready (lane_ready),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active     (active),
    .state      (state),
    .train_err  (train_err)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every valid_out beat must match the head of the expected queue.
  always @(negedge clk_2f) begin
    if (reset === 1'b1 && valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word actual=%h required=none", data_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out actual=%h required=%h", data_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_2f);
    @(negedge clk_2f);
    #1;
  endtask

  task automatic push_com(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(COM);
  endtask

  task automatic chk_drained(input string name);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; init_req = 1'b0; lane_ready = 2'b00; data_in = '0; valid_in = 1'b0;
    tick(); tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_train_err", {31'd0, train_err}, 32'd0);

    // bring-up with both lanes ready
    reset = 1'b1; init_req = 1'b1; lane_ready = 2'b11;
    push_com(16);
    for (int i = 1; i <= 19; i++) begin
      tick();
      if (i == 1) chk("seq_idle", {29'd0, state}, 32'd1);
      if (i == 2) chk("seq_train", {29'd0, state}, 32'd2);
      if (i == 18) chk("pre_active", {31'd0, active}, 32'd0);
    end
    chk("seq_active", {29'd0, state}, 32'd3);
    chk("active_up", {31'd0, active}, 32'd1);
    chk("in_ready_up", {31'd0, in_ready}, 32'd1);
    chk_drained("train1_words");

    // three words then drop init_req (with a simultaneous valid_in that must be ignored)
    valid_in = 1'b1;
    data_in = 32'h11111111; exp_q.push_back(data_in); tick();
    data_in = 32'h22222222; exp_q.push_back(data_in); tick();
    data_in = 32'h33333333; exp_q.push_back(data_in); tick();
    init_req = 1'b0; data_in = 32'hDEADBEEF;
    exp_q.push_back(PAD);
    #1;
    chk("in_ready_drop", {31'd0, in_ready}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk("drain_state", {29'd0, state}, 32'd4);
    chk("drain_active", {31'd0, active}, 32'd1);
    chk("drain_cycle_valid", {31'd0, valid_out}, 32'd0);
    tick();
    chk("odd_exit_state", {29'd0, state}, 32'd1);
    chk("odd_exit_active", {31'd0, active}, 32'd0);
    chk_drained("odd_exit_words");

    // even word count: no pad
    init_req = 1'b1;
    push_com(16);
    for (int i = 0; i < 18; i++) tick();
    chk("retrain_active", {29'd0, state}, 32'd3);
    valid_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_in = 32'hA0000000 | 32'(i);
      exp_q.push_back(data_in);
      tick();
    end
    valid_in = 1'b0; init_req = 1'b0;
    tick();
    chk("even_drain_state", {29'd0, state}, 32'd4);
    chk("even_drain_valid", {31'd0, valid_out}, 32'd0);
    tick();
    chk("even_exit_state", {29'd0, state}, 32'd1);
    chk("even_exit_valid", {31'd0, valid_out}, 32'd0);
    chk_drained("even_exit_words");

    // training timeout with lane 1 never ready
    init_req = 1'b1; lane_ready = 2'b01;
    push_com(16);
    for (int i = 1; i <= 81; i++) begin
      tick();
      if (i == 80) begin
        chk("tmo_pre_state", {29'd0, state}, 32'd2);
        chk("tmo_pre_err", {31'd0, train_err}, 32'd0);
      end
    end
    chk("tmo_state", {29'd0, state}, 32'd1);
    chk("tmo_err", {31'd0, train_err}, 32'd1);
    chk_drained("tmo_words");
    init_req = 1'b0;
    tick();
    chk("tmo_err_sticky", {31'd0, train_err}, 32'd1);
    init_req = 1'b1; lane_ready = 2'b11;
    push_com(16);
    tick();
    chk("tmo_err_clear", {31'd0, train_err}, 32'd0);
    chk("tmo_retrain", {29'd0, state}, 32'd2);
    for (int i = 0; i < 17; i++) tick();
    chk("tmo_recover_active", {29'd0, state}, 32'd3);

    // lane drop with odd parity: pad then retrain
    valid_in = 1'b1; data_in = 32'h55555555; exp_q.push_back(data_in);
    tick();
    valid_in = 1'b0; lane_ready = 2'b10;
    exp_q.push_back(PAD);
    push_com(16);
    tick();
    chk("lane_drop_state", {29'd0, state}, 32'd2);
    chk("lane_drop_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 16; i++) tick();
    chk_drained("lane_drop_words");
    lane_ready = 2'b11;
    tick();
    chk("lane_recover", {29'd0, state}, 32'd3);

    // async reset mid-ACTIVE with odd parity
    valid_in = 1'b1; data_in = 32'h66666666; exp_q.push_back(data_in);
    tick();
    valid_in = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_state", {29'd0, state}, 32'd0);
    chk("async_valid", {31'd0, valid_out}, 32'd0);
    chk("async_data", data_out, 32'd0);
    chk("async_active", {31'd0, active}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    init_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_reset_state", {29'd0, state}, 32'd1);
    chk_drained("post_reset_words");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
